// File: rtl/crack_search_ctrl.sv
// Brute-force decimal candidate generator, result comparator and BCD ms timer.
// Define CRACK_PROGRESS_EN to add the tested_cnt BCD progress output.
module crack_bcd_add #(
  parameter int N = 2
) (
  input  logic [N*4-1:0] value,
  input  logic [3:0]     addend,
  output logic [N*4-1:0] sum,
  output logic           carry
);
  logic [4:0] acc;
  logic [3:0] c;

  always_comb begin
    sum = '0;
    c   = addend;
    acc = '0;
    for (int d = 0; d < N; d++) begin
      acc = {1'b0, value[d*4 +: 4]} + {1'b0, c};
      if (acc >= 5'd10) begin
        sum[d*4 +: 4] = 4'(acc - 5'd10);
        c = 4'd1;
      end else begin
        sum[d*4 +: 4] = acc[3:0];
        c = 4'd0;
      end
    end
    carry = (c != 4'd0);
  end
endmodule

module crack_search_ctrl #(
  parameter int NUM_LANES   = 3,
  parameter int DIGITS      = 8,
  parameter int TIME_DIGITS = 7,
  parameter int TICK_DIV    = 100000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [127:0]                  target_hash,
  output logic                          issue_valid,
  input  logic                          issue_ready,
  output logic [NUM_LANES-1:0]          issue_mask,
  output logic [NUM_LANES*DIGITS*8-1:0] issue_cand,
  input  logic [NUM_LANES-1:0]          res_valid,
  input  logic [NUM_LANES*128-1:0]      res_hash,
  input  logic [NUM_LANES*DIGITS*8-1:0] res_cand,
  output logic                          busy,
  output logic                          found,
  output logic                          exhausted,
  output logic [DIGITS*8-1:0]           answer,
`ifdef CRACK_PROGRESS_EN
  output logic [DIGITS*4-1:0]           tested_cnt,
`endif
  output logic [TIME_DIGITS*4-1:0]      time_bcd
);
  localparam int CW  = DIGITS * 4;
  localparam int AW  = DIGITS * 8;
  localparam int TW  = TIME_DIGITS * 4;
  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OW  = 16;
  localparam int OW1 = OW + 1;

  typedef enum logic [2:0] {IDLE, SEARCH, DRAIN, FOUND, EXHAUSTED} state_t;
  state_t state_reg, state_next;

  logic [127:0]         target_reg;
  logic [CW-1:0]        cnt_reg [NUM_LANES];
  logic [CW-1:0]        cnt_sum [NUM_LANES];
  logic                 ovf_reg [NUM_LANES];
  logic [NUM_LANES-1:0] ovf_vec, cnt_carry, match;
  logic [OW-1:0]        outstanding_reg, outstanding_next;
  logic [OW:0]          out_sum;
  logic [AW-1:0]        answer_reg, match_cand;
  logic                 found_reg, exhausted_reg, match_any;
  logic [PW-1:0]        presc_reg;
  logic [TW-1:0]        time_reg, time_sum;
  logic                 time_carry;
  logic                 busy_c, xfer, start_ok, all_ovf_next;
  logic [3:0]           iss_cnt, res_cnt;

  function automatic logic [3:0] popcnt(input logic [NUM_LANES-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_LANES; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  assign busy_c       = (state_reg == SEARCH) || (state_reg == DRAIN);
  assign issue_valid  = (state_reg == SEARCH);
  assign xfer         = issue_valid && issue_ready;
  assign start_ok     = start && !abort && !busy_c;
  assign all_ovf_next = &(ovf_vec | cnt_carry);

  genvar gi, gd;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      crack_bcd_add #(.N(DIGITS)) u_add (
        .value  (cnt_reg[gi]),
        .addend (4'(NUM_LANES)),
        .sum    (cnt_sum[gi]),
        .carry  (cnt_carry[gi])
      );
      assign ovf_vec[gi]    = ovf_reg[gi];
      assign issue_mask[gi] = issue_valid && !ovf_reg[gi];
      assign match[gi]      = res_valid[gi] && (res_hash[gi*128 +: 128] == target_reg);
      for (gd = 0; gd < DIGITS; gd++) begin : g_digit
        assign issue_cand[gi*AW + gd*8 +: 8] = {4'h3, cnt_reg[gi][gd*4 +: 4]};
      end
      // Lane gi walks gi, gi+N, gi+2N ... so the lanes interleave the space.
      always_ff @(posedge clk) begin
        if (!reset_n || start_ok) begin
          cnt_reg[gi] <= CW'(gi);
          ovf_reg[gi] <= 1'b0;
        end else if (xfer) begin
          cnt_reg[gi] <= cnt_sum[gi];
          ovf_reg[gi] <= ovf_reg[gi] | cnt_carry[gi];
        end
      end
    end
  endgenerate

  // Scan high to low so the lowest matching lane is the one that sticks.
  always_comb begin
    match_any  = 1'b0;
    match_cand = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (match[i]) begin
        match_any  = 1'b1;
        match_cand = res_cand[i*AW +: AW];
      end
    end
  end

  assign iss_cnt = xfer ? popcnt(issue_mask) : 4'd0;
  assign res_cnt = popcnt(res_valid);
  assign out_sum = {1'b0, outstanding_reg} + OW1'(iss_cnt);
  assign outstanding_next = (out_sum < OW1'(res_cnt)) ? '0 : OW'(out_sum - OW1'(res_cnt));

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, FOUND, EXHAUSTED: if (start) state_next = SEARCH;
      SEARCH: begin
        if (match_any)                  state_next = FOUND;
        else if (xfer && all_ovf_next)  state_next = DRAIN;
      end
      DRAIN: begin
        if (match_any)                  state_next = FOUND;
        else if (outstanding_next == '0) state_next = EXHAUSTED;
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  crack_bcd_add #(.N(TIME_DIGITS)) u_time (
    .value  (time_reg),
    .addend (4'd1),
    .sum    (time_sum),
    .carry  (time_carry)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      target_reg      <= '0;
      outstanding_reg <= '0;
      answer_reg      <= {DIGITS{8'h30}};
      found_reg       <= 1'b0;
      exhausted_reg   <= 1'b0;
      presc_reg       <= '0;
      time_reg        <= '0;
    end else if (start_ok) begin
      target_reg      <= target_hash;
      outstanding_reg <= '0;
      found_reg       <= 1'b0;
      exhausted_reg   <= 1'b0;
      presc_reg       <= '0;
      time_reg        <= '0;
    end else if (busy_c) begin
      outstanding_reg <= outstanding_next;
      if (!abort && match_any) begin
        answer_reg <= match_cand;
        found_reg  <= 1'b1;
      end else if (!abort && state_reg == DRAIN && outstanding_next == '0) begin
        exhausted_reg <= 1'b1;
      end
      // A carry out of the top digit means all 9s: hold there.
      if (presc_reg == PW'(TICK_DIV - 1)) begin
        presc_reg <= '0;
        if (!time_carry) time_reg <= time_sum;
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
    end
  end

`ifdef CRACK_PROGRESS_EN
  logic [CW-1:0] tested_reg, tested_sum;
  logic          tested_carry;

  crack_bcd_add #(.N(DIGITS)) u_tested (
    .value  (tested_reg),
    .addend (res_cnt),
    .sum    (tested_sum),
    .carry  (tested_carry)
  );

  always_ff @(posedge clk) begin
    if (!reset_n || start_ok) tested_reg <= '0;
    else if (busy_c)          tested_reg <= tested_carry ? {DIGITS{4'h9}} : tested_sum;
  end

  assign tested_cnt = tested_reg;
`endif

  assign busy      = busy_c;
  assign found     = found_reg;
  assign exhausted = exhausted_reg;
  assign answer    = answer_reg;
  assign time_bcd  = time_reg;
endmodule

// File: doc/crack_search_ctrl.md
Name: crack_search_ctrl

Overview:
- Parametrised brute-force search controller for parallel hash-cracking.
- Generates decimal ASCII password candidates and dispatches them to NUM_LANES external hash engines of arbitrary, fixed latency.
- Compares each returned hash against a target, latches the matching candidate, and runs a BCD millisecond timer for the display layer.
- Adds exhaustion detection, abort and restart over the fixed 3-engine, 8-digit search.

Parameters:
- NUM_LANES, 3, number of parallel hash engines (1..9).
- DIGITS, 8, candidate length in ASCII decimal characters.
- TIME_DIGITS, 7, BCD digits of the elapsed-ms timer.
- TICK_DIV, 100000, clk cycles per millisecond.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle pulse: begin or restart search.
- abort  in  1  single-cycle pulse: return to idle.
- target_hash  in  128  hash to match; sampled on accepted start.
- issue_valid  out  1  candidate batch valid.
- issue_ready  in  1  all engines accept a batch this cycle.
- issue_mask  out  NUM_LANES  per-lane candidate-valid.
- issue_cand  out  NUM_LANES*DIGITS*8  lane i at bits [i*DIGITS*8 +: DIGITS*8], MS character highest.
- res_valid  in  NUM_LANES  per-lane result strobe.
- res_hash  in  NUM_LANES*128  per-lane hash.
- res_cand  in  NUM_LANES*DIGITS*8  candidate echoed with its hash.
- busy  out  1  high in SEARCH or DRAIN.
- found  out  1  match latched.
- exhausted  out  1  space fully tested, no match.
- answer  out  DIGITS*8  matching candidate, ASCII.
- time_bcd  out  TIME_DIGITS*4  elapsed ms, BCD, LS digit at [3:0].

Behaviour:
- Reset: state IDLE; issue_valid=0; issue_mask=0; busy=0; found=0; exhausted=0; answer=all "0"; time_bcd=0; outstanding counter=0.
- States: IDLE, SEARCH, DRAIN, FOUND, EXHAUSTED.
- IDLE -> SEARCH on start:
  - latch target_hash;
  - lane i counter loads value i (BCD);
  - clear timer, found and exhausted.
- SEARCH:
  - issue_valid=1;
  - lane i candidate = ASCII of its BCD counter;
  - issue_mask[i]=1 iff counter <= 10^DIGITS-1.
- Batch transfer: when issue_valid && issue_ready, every lane counter adds NUM_LANES in BCD (single-digit add, ripple carry). A lane overflowing past all 9s sets its overflow flag; its mask stays 0 from then on.
- SEARCH -> DRAIN: on the transfer cycle that leaves all lanes overflowed.
- Outstanding counter: += popcount(issue_mask) on transfer; -= popcount(res_valid); both may occur in the same cycle (net update).
- Compare (SEARCH/DRAIN only): res_valid[i] && res_hash[i]==latched target.
  - Lowest matching lane wins.
  - Next cycle: answer<=res_cand of that lane; found=1; state FOUND; issue_valid=0.
  - No further transfers.
- DRAIN -> EXHAUSTED: when outstanding reaches 0 with no match in that cycle. A match in that same cycle wins (FOUND).
- FOUND / EXHAUSTED:
  - hold answer and time_bcd;
  - ignore res_valid;
  - start restarts exactly as from IDLE, discarding late results and resetting outstanding to 0.
- abort in any state -> IDLE next cycle: busy=0, issue_valid=0. answer/found/exhausted hold until next start.
- start while SEARCH/DRAIN: ignored.
- Timer:
  - prescaler counts 0..TICK_DIV-1 while busy;
  - BCD increment on wrap, decimal ripple;
  - saturates at all 9s;
  - frozen outside SEARCH/DRAIN.
- Reset mid-search: all state returns to reset values on the next edge.

Optional Feature:
- Macro CRACK_PROGRESS_EN.
- Defined: adds output tested_cnt (DIGITS*4 bits, BCD).
  - Cleared on start.
  - Incremented by popcount(res_valid) per cycle in SEARCH/DRAIN.
  - Saturates at all 9s.
  - Frozen otherwise.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Bench setup: DIGITS=2, NUM_LANES=3, TICK_DIV=4. Stub engines return hash = zero-extended candidate ASCII after 5 cycles, issue_ready=1.
- Exact match: target=ext("07"), start -> found=1, answer="07", busy=0, issue_valid=0 within 6 cycles of lane 1 issuing "07"; later results ignored.
- Exhaustion: target=ext("XX") -> batches 00/01/02 ... 99, with final batch issue_mask=3'b001. Then DRAIN; exhausted=1 one cycle after last result; found=0.
- Simultaneous match: target matched by both lane 0 and lane 2 in the same cycle (bench forces it) -> answer=lane 0 candidate.
- Backpressure: issue_ready toggling 1/0 each cycle -> counters advance only on ready cycles; no candidate skipped or duplicated (scoreboard over 00..99).
- Abort/restart: abort at cycle 10 of SEARCH -> IDLE next cycle, timer frozen. start -> candidates restart at 00/01/02, time_bcd=0 then increments every 4 busy cycles.
- Reset: reset_n=0 for 1 cycle mid-DRAIN -> all outputs at reset values next cycle. With CRACK_PROGRESS_EN, after exhaustion tested_cnt="00" saturated? No: tested_cnt=99 (saturated at 100 results).
